// File: rtl/ro_freq_meter.sv
// ro_freq_meter: ring-oscillator channel mux plus on-chip frequency meter.
//
// A start request latches a channel, a gate length and (optionally) scan mode.
// The meter then enables the oscillators, waits SETTLE_CYC cycles so that the
// edge synchronizer flushes, and counts rising edges of the latched channel for
// gate_len clock cycles. The count is published one cycle after the DONE state,
// together with a one-cycle result_valid_o pulse.
//
// Optional feature: define RO_SCAN_EN to enable scan mode. In that mode a start
// with scan_i=1 measures channels 0..N_CH-1 back to back with the same gate.
// Without the macro, scan_i is ignored.
//
// Ports:
//   wb_clk_i        clock
//   wb_rst_n_i      asynchronous active-low reset
//   ro_in           pre-divided oscillator outputs (asynchronous)
//   ch_sel          channel for the pad mux and for single measurements
//   gate_len        gate length in clock cycles
//   start_i         measurement request
//   scan_i          scan-mode request (RO_SCAN_EN only)
//   ro_en_o         oscillator enable
//   busy_o          measurement in progress
//   result_o        last edge count
//   result_ch_o     channel that produced result_o
//   result_valid_o  one-cycle pulse when a new result is published
//   overflow_o      last result saturated
//   mux_out_o       combinational ro_in[ch_sel], 0 for out-of-range channels

module ro_freq_meter #(
    parameter int unsigned N_CH       = 10,
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned GATE_W     = 20,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [N_CH-1:0]   ro_in,
    input  logic [SEL_W-1:0]  ch_sel,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              start_i,
    input  logic              scan_i,
    output logic              ro_en_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  result_o,
    output logic [SEL_W-1:0]  result_ch_o,
    output logic              result_valid_o,
    output logic              overflow_o,
    output logic              mux_out_o
);

    localparam int unsigned NPad = 2 ** SEL_W;
    localparam int unsigned SetW = $clog2(SETTLE_CYC);

    typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic              scan_q, scan_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  result_q, result_d;
    logic [SEL_W-1:0]  result_ch_q, result_ch_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;
    logic              s1_q, s2_q, s3_q;

    // Pad ro_in to the full select range so out-of-range channels read as 0.
    logic [NPad-1:0] ro_pad;
    always_comb begin
        ro_pad = '0;
        ro_pad[N_CH-1:0] = ro_in;
    end

    assign mux_out_o = ro_pad[ch_sel];

    logic edge_det;
    assign edge_det = s2_q & ~s3_q;

    logic scan_more;
    assign scan_more = scan_q && (ch_q != SEL_W'(N_CH - 1));

`ifdef RO_SCAN_EN
    logic unused_scan;
    assign unused_scan = 1'b0;
`else
    logic unused_scan;
    assign unused_scan = scan_i;
`endif

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        gate_d      = gate_q;
        scan_d      = scan_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        settle_d    = settle_q;
        gate_cnt_d  = gate_cnt_q;
        result_d    = result_q;
        result_ch_d = result_ch_q;
        overflow_d  = overflow_q;
        valid_d     = 1'b0;
        ro_en_o     = 1'b0;
        busy_o      = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
                if (start_i) begin
`ifdef RO_SCAN_EN
                    scan_d = scan_i;
                    ch_d   = scan_i ? '0 : ch_sel;
`else
                    scan_d = 1'b0;
                    ch_d   = ch_sel;
`endif
                    gate_d   = gate_len;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                ro_en_o  = 1'b1;
                settle_d = settle_q + SetW'(1);
                if (settle_q == SetW'(SETTLE_CYC - 1)) begin
                    gate_cnt_d = '0;
                    state_d    = (gate_q == '0) ? StDone : StGate;
                end
            end
            StGate: begin
                ro_en_o    = 1'b1;
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                if (edge_det) begin
                    // Saturate and remember that this measurement overflowed.
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (gate_cnt_q == gate_q - GATE_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ro_en_o     = scan_more;
                result_d    = cnt_q;
                result_ch_d = ch_q;
                overflow_d  = ovf_q;
                valid_d     = 1'b1;
                if (scan_more) begin
                    ch_d     = ch_q + SEL_W'(1);
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    settle_d = '0;
                    state_d  = StSettle;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            gate_q      <= '0;
            scan_q      <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            settle_q    <= '0;
            gate_cnt_q  <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
            overflow_q  <= 1'b0;
            valid_q     <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            gate_q      <= gate_d;
            scan_q      <= scan_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            settle_q    <= settle_d;
            gate_cnt_q  <= gate_cnt_d;
            result_q    <= result_d;
            result_ch_q <= result_ch_d;
            overflow_q  <= overflow_d;
            valid_q     <= valid_d;
            // Only the latched channel is synchronized; SETTLE flushes it.
            s1_q        <= ro_pad[ch_q];
            s2_q        <= s1_q;
            s3_q        <= s2_q;
        end
    end

    assign result_o       = result_q;
    assign result_ch_o    = result_ch_q;
    assign overflow_o     = overflow_q;
    assign result_valid_o = valid_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
module tb_ro_freq_meter;

    localparam int SETTLE = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  ro_in = '0;
    logic [3:0]  ch_sel = '0;
    logic [19:0] gate_len = '0;
    logic        start_i = 1'b0;
    logic        scan_i = 1'b0;
    logic        ro_en_o, busy_o, result_valid_o, overflow_o, mux_out_o;
    logic [7:0]  result_o;
    logic [3:0]  result_ch_o;

    ro_freq_meter #(
        .N_CH      (10),
        .SEL_W     (4),
        .CNT_W     (8),
        .GATE_W    (20),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .ro_in         (ro_in),
        .ch_sel        (ch_sel),
        .gate_len      (gate_len),
        .start_i       (start_i),
        .scan_i        (scan_i),
        .ro_en_o       (ro_en_o),
        .busy_o        (busy_o),
        .result_o      (result_o),
        .result_ch_o   (result_ch_o),
        .result_valid_o(result_valid_o),
        .overflow_o    (overflow_o),
        .mux_out_o     (mux_out_o)
    );

    always #5 clk = ~clk;

    // Oscillator model: channel k is a square wave of per[k] clock cycles.
    int         per[10];
    int         cyc = 0;
    logic       ovr_en = 1'b0;
    logic [9:0] ovr_pat = '0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 10; k++) begin
                if (ovr_en) ro_in[k] = ovr_pat[k];
                else ro_in[k] = (per[k] > 1) && ((cyc % per[k]) < (per[k] / 2));
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo,
                           input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Issue one start and wait for the first valid pulse. lat is the number of
    // cycles from the sampling edge to the pulse (-1 on timeout); en counts the
    // cycles ro_en_o was high before the pulse.
    task automatic run_meas(input logic [3:0] ch, input int gl, input logic scan,
                            output int lat, output int en);
        int n;
        @(negedge clk);
        ch_sel = ch; gate_len = 20'(gl); scan_i = scan; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; scan_i = 1'b0;
        lat = -1; en = 0; n = 0;
        while (n < gl + SETTLE + 100) begin
            if (result_valid_o) begin
                lat = n;
                break;
            end
            if (ro_en_o) en++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Count valid pulses over a number of following cycles.
    task automatic count_pulses(input int ncyc, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (result_valid_o) pulses++;
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] ch;
        int         period;
        int         gl;
        int         lo;
        int         hi;
        logic       ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, en, pulses, n, idx, busy_bad;
        logic [9:0] pats[2];

        vecs[0] = '{"single8",  4'd3,  8,  800, 99,  101, 1'b0};
        vecs[1] = '{"zerogate", 4'd3,  8,    0,  0,    0, 1'b0};
        vecs[2] = '{"saturate", 4'd0,  4, 2000, 255, 255, 1'b1};
        vecs[3] = '{"post_sat", 4'd0,  4,   40,  9,   11, 1'b0};
        vecs[4] = '{"badchan",  4'd12, 4,   50,  0,    0, 1'b0};
        vecs[5] = '{"lastchan", 4'd9, 10,  200, 19,   21, 1'b0};
        for (int k = 0; k < 10; k++) per[k] = 4 + k;

        // Reset state
        #23;
        chk("rst_busy", busy_o, 0);
        chk("rst_ro_en", ro_en_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_result_ch", result_ch_o, 0);
        chk("rst_valid", result_valid_o, 0);
        chk("rst_ovf", overflow_o, 0);
        @(negedge clk); rst_n = 1'b1;

        // Pad mux, including out-of-range selects
        pats[0] = 10'b1011001110;
        pats[1] = ~pats[0];
        ovr_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            ovr_pat = pats[p];
            @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                @(posedge clk); #2;
                ch_sel = 4'(c);
                #1;
                chk($sformatf("mux_p%0d_c%0d", p, c), mux_out_o,
                    (c < 10) ? longint'(pats[p][c]) : 0);
            end
        end
        ovr_en = 1'b0;

        // Table-driven single measurements
        for (int v = 0; v < 6; v++) begin
            per[vecs[v].ch % 10] = vecs[v].period;
            run_meas(vecs[v].ch, vecs[v].gl, 1'b0, lat, en);
            chk({vecs[v].name, "_latency"}, lat, SETTLE + vecs[v].gl + 1);
            chk({vecs[v].name, "_ro_en_cycles"}, en, SETTLE + vecs[v].gl);
            chk_rng({vecs[v].name, "_result"}, result_o, vecs[v].lo, vecs[v].hi);
            chk({vecs[v].name, "_result_ch"}, result_ch_o, vecs[v].ch);
            chk({vecs[v].name, "_ovf"}, overflow_o, vecs[v].ovf);
        end
        for (int k = 0; k < 10; k++) per[k] = 4 + k;

        // Inputs ignored while busy
        per[2] = 6;
        @(negedge clk);
        ch_sel = 4'd2; gate_len = 20'd120; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1; n = 0;
        while (n < 400) begin
            if (n == 30) begin
                start_i = 1'b1; ch_sel = 4'd5; gate_len = 20'd3; scan_i = 1'b1;
            end
            if (n == 32) begin
                start_i = 1'b0; scan_i = 1'b0;
            end
            if (result_valid_o) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("busy_ignore_latency", lat, SETTLE + 120 + 1);
        chk("busy_ignore_ch", result_ch_o, 2);
        chk_rng("busy_ignore_result", result_o, 19, 21);
        count_pulses(60, pulses);
        chk("busy_ignore_extra_pulses", pulses, 0);

        // Reset during GATE aborts without a pulse
        @(negedge clk);
        ch_sel = 4'd2; gate_len = 20'd300; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_ro_en", ro_en_o, 0);
        chk("abort_result", result_o, 0);
        count_pulses(4, pulses);
        @(negedge clk); rst_n = 1'b1;
        count_pulses(20, pulses);
        chk("abort_no_pulse", pulses, 0);
        per[3] = 8;
        run_meas(4'd3, 80, 1'b0, lat, en);
        chk("after_abort_latency", lat, SETTLE + 80 + 1);
        chk_rng("after_abort_result", result_o, 9, 11);

`ifdef RO_SCAN_EN
        // Scan over all channels
        for (int k = 0; k < 10; k++) per[k] = 4 + k;
        @(negedge clk);
        ch_sel = 4'd5; gate_len = 20'd1000; scan_i = 1'b1; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; scan_i = 1'b0;
        idx = 0; busy_bad = 0; n = 0;
        while (idx < 10 && n < 12000) begin
            if (result_valid_o) begin
                chk($sformatf("scan_ch_%0d", idx), result_ch_o, idx);
                chk_rng($sformatf("scan_result_%0d", idx), result_o,
                        1000 / (4 + idx) - 1, 1000 / (4 + idx) + 1);
                idx++;
            end else if (!busy_o) begin
                busy_bad++;
            end
            @(posedge clk); #1;
            n++;
        end
        chk("scan_pulses", idx, 10);
        chk("scan_busy_gaps", busy_bad, 0);
        count_pulses(40, pulses);
        chk("scan_extra_pulses", pulses, 0);
        chk("scan_end_busy", busy_o, 0);
`else
        // scan_i has no effect: a single measurement on ch_sel
        per[4] = 8;
        run_meas(4'd4, 60, 1'b1, lat, en);
        chk("noscan_latency", lat, SETTLE + 60 + 1);
        chk("noscan_ch", result_ch_o, 4);
        chk_rng("noscan_result", result_o, 7, 8);
        count_pulses(40, pulses);
        chk("noscan_extra_pulses", pulses, 0);
        chk("noscan_end_busy", busy_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
